// File: rtl/jtframe_dual_ram_loader_pkg.sv
// ----------------------------------------------------------------------------
// jtframe_dual_ram_loader_pkg: sizing helpers shared by the loader and packer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package jtframe_dual_ram_loader_pkg;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtframe_dual_ram_loader_pack.sv
// ----------------------------------------------------------------------------
// jtframe_dual_ram_loader_pack: little-endian byte packer with flush padding.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtframe_dual_ram_loader_pack
  import jtframe_dual_ram_loader_pkg::*;
#(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          flush_i,
  input  logic [7:0]    data_i,
  output logic [dw-1:0] word_o,
  output logic          full_o,
  output logic          pending_o
);

  localparam int NB = bytes_per_word(dw);
  localparam int CW = cnt_width(NB);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [dw-1:0] pack_q, pack_d;
  logic [dw-1:0] merged;

  always_comb begin
    merged = pack_q;
    for (int i = 0; i < NB; i++) begin
      if (cnt_q == CW'(i)) merged[i*8 +: 8] = data_i;
    end
  end

  // Unfilled lanes are always zero, so pack_q is already the padded flush word.
  assign full_o = push_i && (cnt_q == CW'(NB - 1));
  assign word_o = push_i ? merged : pack_q;

  always_comb begin
    cnt_d  = cnt_q;
    pack_d = pack_q;
    if (clr_i || flush_i || full_o) begin
      cnt_d  = '0;
      pack_d = '0;
    end else if (push_i) begin
      cnt_d  = cnt_q + CW'(1);
      pack_d = merged;
    end
  end

  assign pending_o = (cnt_d != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pack_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtframe_dual_ram_loader.sv
// ----------------------------------------------------------------------------
// jtframe_dual_ram_loader: clears, downloads into and forwards user writes to
// port 0 of a dual-port RAM.   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtframe_dual_ram_loader
  import jtframe_dual_ram_loader_pkg::*;
#(
  parameter int            dw     = 8,
  parameter int            aw     = 10,
  parameter logic [dw-1:0] clrval = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  input  logic          dl_start,
  input  logic [aw-1:0] dl_addr,
  input  logic          dl_valid,
  input  logic [7:0]    dl_data,
  input  logic          dl_end,
  output logic          dl_ready,
  input  logic [aw-1:0] usr_addr,
  input  logic [dw-1:0] usr_data,
  input  logic          usr_we,
  output logic [aw-1:0] ram_addr,
  output logic [dw-1:0] ram_data,
  output logic          ram_we,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [aw-1:0] sweep_q, sweep_d;
  logic [aw-1:0] ptr_q, ptr_d;
  logic [aw-1:0] ram_addr_q, ram_addr_d;
  logic [dw-1:0] ram_data_q, ram_data_d;
  logic          ram_we_q, ram_we_d;
  logic          done_q, done_d;

  logic          pk_clr, pk_push, pk_flush;
  logic [dw-1:0] pk_word;
  logic          pk_full, pk_pending;

  jtframe_dual_ram_loader_pack #(
    .dw (dw)
  ) u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (pk_clr),
    .push_i    (pk_push),
    .flush_i   (pk_flush),
    .data_i    (dl_data),
    .word_o    (pk_word),
    .full_o    (pk_full),
    .pending_o (pk_pending)
  );

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    ptr_d      = ptr_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    pk_clr     = 1'b0;
    pk_push    = 1'b0;
    pk_flush   = 1'b0;
    case (state_q)
      CLEAR: begin
        ram_we_d   = 1'b1;
        ram_addr_d = sweep_q;
        ram_data_d = clrval;
        // A repeated clear request rewinds the sweep instead of finishing it.
        if (clr_req) begin
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + aw'(1);
          if (sweep_q == {aw{1'b1}}) state_d = IDLE;
        end
      end
      IDLE: begin
        ram_addr_d = usr_addr;
        ram_data_d = usr_data;
        if (clr_req) begin
          state_d = CLEAR;
          sweep_d = '0;
        end else if (dl_start) begin
          state_d = LOAD;
          ptr_d   = dl_addr;
          pk_clr  = 1'b1;
        end else begin
          ram_we_d = usr_we;
        end
      end
      LOAD: begin
        if (clr_req) begin
          state_d = CLEAR;
          sweep_d = '0;
          pk_clr  = 1'b1;
        end else begin
          pk_push = dl_valid;
          if (pk_full) begin
            ram_we_d   = 1'b1;
            ram_addr_d = ptr_q;
            ram_data_d = pk_word;
            ptr_d      = ptr_q + aw'(1);
          end
          if (dl_end) state_d = pk_pending ? FLUSH : IDLE;
        end
      end
      default: begin
        if (clr_req) begin
          state_d = CLEAR;
          sweep_d = '0;
          pk_clr  = 1'b1;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = ptr_q;
          ram_data_d = pk_word;
          ptr_d      = ptr_q + aw'(1);
          pk_flush   = 1'b1;
          state_d    = IDLE;
        end
      end
    endcase
    done_d = (state_d == IDLE) && (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      sweep_q    <= '0;
      ptr_q      <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      ptr_q      <= ptr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      done_q     <= done_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_we   = ram_we_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign dl_ready = (state_q == LOAD);

endmodule

`default_nettype wire
